// File: rtl/jerky_checker.sv
// -----------------------------------------------------------------------------
// jerky_checker
//
// Purpose:
//   Tracks a free-running "jerky" counter whose value moves in a repeating
//   +2, +2, -1 step cycle starting at 0 (0,2,4,3,5,7,6,8,...), all modulo 256.
//   Each rising edge the observed value is compared against a registered
//   prediction. A mismatch produces a one-cycle error pulse and bumps a
//   saturating mismatch counter, then the checker either stops checking
//   (sticky FAIL) or, when the optional resynchronisation feature is built in,
//   hunts for the step pattern again and relocks on it.
//
// Configuration:
//   JERKY_CHK_RESYNC_EN  - when defined, a mismatch enters RESYNC instead of
//                          the sticky FAIL state. Without it the RESYNC state
//                          and its sample window are not built.
//
// Parameters:
//   ERR_W        - width of the saturating mismatch counter.
//
// Ports:
//   clock_i      - system clock, rising edge active.
//   reset_i      - asynchronous active-high reset.
//   count_i      - sampled value of the observed counter.
//   expected_o   - registered prediction of the next count_i sample.
//   locked_o     - high while the checker is in CHECK.
//   error_o      - one-cycle pulse per detected mismatch.
//   err_count_o  - saturating number of mismatches seen in CHECK.
//
// Every output is driven straight from a flop; count_i only feeds next-state
// logic.
// -----------------------------------------------------------------------------
module jerky_checker #(
    parameter int ERR_W = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [7:0]       count_i,
    output logic [7:0]       expected_o,
    output logic             locked_o,
    output logic             error_o,
    output logic [ERR_W-1:0] err_count_o
);

    // Step amounts; -1 is represented as its 8-bit two's complement so that
    // plain addition wraps modulo 256.
    localparam logic [7:0]       STEP_UP   = 8'd2;
    localparam logic [7:0]       STEP_DOWN = 8'hFF;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

`ifdef JERKY_CHK_RESYNC_EN
    typedef enum logic [1:0] {
        CHECK  = 2'd0,
        FAIL   = 2'd1,
        RESYNC = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        CHECK  = 2'd0,
        FAIL   = 2'd1
    } state_t;
`endif

    // Step applied when leaving phase ph: phases 0 and 1 climb, phase 2 dips.
    function automatic logic [7:0] step_of(input logic [1:0] ph);
        return (ph == 2'd2) ? STEP_DOWN : STEP_UP;
    endfunction

    // Phase sequence 0 -> 1 -> 2 -> 0. The unused encoding 3 falls back to 0.
    function automatic logic [1:0] phase_after(input logic [1:0] ph);
        return (ph == 2'd2) ? 2'd0 : ph + 2'd1;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [7:0]       exp_q,    exp_d;
    logic [1:0]       phase_q,  phase_d;
    logic             locked_q, locked_d;
    logic             error_q,  error_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;

`ifdef JERKY_CHK_RESYNC_EN
    // Sliding window of the two most recent samples taken in RESYNC; the
    // third sample of the window is count_i itself on the deciding edge.
    logic [7:0]       s0_q,   s0_d;
    logic [7:0]       s1_q,   s1_d;
    logic [1:0]       fill_q, fill_d;
    logic [7:0]       delta1, delta2;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        phase_d  = phase_q;
        error_d  = 1'b0;
        errcnt_d = errcnt_q;
`ifdef JERKY_CHK_RESYNC_EN
        s0_d     = s0_q;
        s1_d     = s1_q;
        fill_d   = fill_q;
        delta1   = s1_q - s0_q;
        delta2   = count_i - s1_q;
`endif

        case (state_q)
            CHECK: begin
                if (count_i == exp_q) begin
                    exp_d   = exp_q + step_of(phase_q);
                    phase_d = phase_after(phase_q);
                end else begin
                    // The prediction is left untouched so that FAIL keeps
                    // showing the value that was missed.
                    error_d = 1'b1;
                    if (errcnt_q != ERR_MAX) begin
                        errcnt_d = errcnt_q + ERR_ONE;
                    end
`ifdef JERKY_CHK_RESYNC_EN
                    state_d = RESYNC;
                    fill_d  = 2'd0;
`else
                    state_d = FAIL;
`endif
                end
            end

            FAIL: begin
                // Sticky until reset; everything holds.
            end

`ifdef JERKY_CHK_RESYNC_EN
            RESYNC: begin
                case (fill_q)
                    2'd0: begin
                        s0_d   = count_i;
                        fill_d = 2'd1;
                    end
                    2'd1: begin
                        s1_d   = count_i;
                        fill_d = 2'd2;
                    end
                    default: begin
                        // Each legal pair of consecutive steps pins down
                        // where in the cycle the counter is, hence the next
                        // step and the phase that follows it.
                        if (delta1 == STEP_UP && delta2 == STEP_UP) begin
                            exp_d   = count_i + STEP_DOWN;
                            phase_d = 2'd0;
                            state_d = CHECK;
                        end else if (delta1 == STEP_UP && delta2 == STEP_DOWN) begin
                            exp_d   = count_i + STEP_UP;
                            phase_d = 2'd1;
                            state_d = CHECK;
                        end else if (delta1 == STEP_DOWN && delta2 == STEP_UP) begin
                            exp_d   = count_i + STEP_UP;
                            phase_d = 2'd2;
                            state_d = CHECK;
                        end else begin
                            s0_d = s1_q;
                            s1_d = count_i;
                        end
                    end
                endcase
            end
`endif

            default: begin
                state_d = CHECK;
            end
        endcase

        // locked is registered from the next state so it lines up with the
        // state register instead of being decoded after it.
        locked_d = (state_d == CHECK);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= CHECK;
            exp_q    <= 8'd0;
            phase_q  <= 2'd0;
            locked_q <= 1'b1;
            error_q  <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            phase_q  <= phase_d;
            locked_q <= locked_d;
            error_q  <= error_d;
            errcnt_q <= errcnt_d;
        end
    end

`ifdef JERKY_CHK_RESYNC_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s0_q   <= 8'd0;
            s1_q   <= 8'd0;
            fill_q <= 2'd0;
        end else begin
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            fill_q <= fill_d;
        end
    end
`endif

    assign expected_o  = exp_q;
    assign locked_o    = locked_q;
    assign error_o     = error_q;
    assign err_count_o = errcnt_q;

endmodule

// File: doc/jerky_checker.md
JERKY_CHECKER -- requirements
Module: jerky_checker

Interface
REQ-001 Parameter: ERR_W, default 8, width of the saturating mismatch counter err_count.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; no other reset exists.
REQ-004 count  input  8  value observed from the jerky counter, sampled each rising edge while reset is low.
REQ-005 expected  output  8  registered prediction of the next sample of count.
REQ-006 locked  output  1  high only while the FSM is in CHECK.
REQ-007 error  output  1  one-cycle registered pulse per detected mismatch.
REQ-008 err_count  output  ERR_W  saturating count of mismatches detected in CHECK.

Function
REQ-009 Reference pattern SHALL be a step cycle of +2, +2, -1, held in phase register p = 0, 1, 2 (steps +2, +2, -1), with the sequence starting at 0: 0,2,4,3,5,7,6,8,...
REQ-010 Arithmetic SHALL be modulo 256 on 8 bits with no overflow flag: 254+2 gives 0, 0-1 gives 255.
REQ-011 FSM states SHALL be CHECK, FAIL and RESYNC (RESYNC exists only with the macro of REQ-022).
REQ-012 CHECK, count == expected: expected <= expected + step(p); p <= (p+1) mod 3; error <= 0.
REQ-013 CHECK, count != expected: error <= 1 for exactly one cycle; err_count increments unless already at 2^ERR_W-1; next state per REQ-022/023.
REQ-014 Mismatch latency SHALL be exactly one cycle: error and err_count update on the edge that samples the bad value and are visible in the following cycle.
REQ-015 In FAIL and RESYNC, err_count SHALL hold its value and error SHALL stay 0.
REQ-016 expected SHALL hold its value in FAIL.
REQ-017 All outputs SHALL come directly from registers; there SHALL be no combinational path from count to any output.

Reset
REQ-018 Asserting reset SHALL immediately, without waiting for a clock edge, force: state = CHECK, expected = 0, p = 0, locked = 1, error = 0, err_count = 0.
REQ-019 Reset asserted mid-operation, including in FAIL or RESYNC, SHALL discard all history and give the same values as REQ-018.
REQ-020 The first rising edge after reset deasserts SHALL compare count against 0.
REQ-021 While reset is high, count SHALL be ignored.

Configuration
REQ-022 With macro JERKY_CHK_RESYNC_EN defined, a mismatch SHALL move the FSM from CHECK to RESYNC.
  - RESYNC captures three consecutive samples s0, s1, s2 and forms deltas d1 = s1-s0 and d2 = s2-s1 (mod 256).
  - Delta pairs (+2,+2), (+2,-1) and (-1,+2) SHALL set expected = s2 + next step, with p at the following phase, and return to CHECK.
  - Next step is -1 after (+2,+2); +2 at p=1 after (+2,-1); +2 at p=2 after (-1,+2).
  - Any other pair SHALL slide the window (s0 <= s1, s1 <= s2) and keep the FSM in RESYNC.
REQ-023 Without JERKY_CHK_RESYNC_EN, a mismatch SHALL move the FSM to FAIL, which is sticky until reset; RESYNC logic SHALL be absent.

Verification
REQ-024 Reset, then drive 0,2,4,3,5,7,6,8,10,9,11,13 -> locked=1 throughout, error=0, err_count=0, expected=12 afterwards.
REQ-025 Clean sequence through wrap, driving ...,252,254,0,255,1,3 -> no error; expected after 254 is 0, after 0 is 255.
REQ-026 Without macro, drive 9 where 8 is expected -> error=1 for exactly one cycle, err_count=1, locked=0 and FAIL held for 20 more cycles until reset.
REQ-027 With macro, drive ...,6,9 (bad), then 12,11,13 -> error pulse once, locked=0 for 3 samples, then locked=1, expected=15 and the next 15 matches.
REQ-028 Assert reset asynchronously mid-cycle while expected=7 -> all outputs reach REQ-018 values before the next edge; after release, 0 is accepted.
REQ-029 With ERR_W=2 and the macro, inject 5 separated mismatches, each followed by recovery -> err_count reads 1,2,3,3,3 and 5 error pulses occur.
